// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if -- core request/response channel plus memory bus of the
// load/store unit controller.
//   req_*  : core -> controller request (valid/ready handshake)
//   resp_* : controller -> core one-cycle completion pulse
//   mem_*  : controller <-> memory request/grant and read-data return
// Modports:
//   slave  : the controller itself (lsu_ctrl)
//   master : the environment driving the core and memory sides
interface lsu_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;

    logic        resp_valid_o;
    logic        resp_err_o;
    logic [31:0] resp_rdata_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- single-outstanding RV32I load/store controller.
// Accepts one load/store from the core, checks alignment and funct3,
// issues a word-aligned memory request with byte enables and replicated
// store data, waits for grant / read data, and returns a one-cycle
// response with extended load data or an error (misaligned, illegal
// funct3, or timeout after TIMEOUT cycles in REQ plus WAIT).
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : lsu_ctrl_if.slave (core request/response + memory bus)
// Parameter:
//   TIMEOUT : 1..65535, cycles allowed in REQ plus WAIT
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic      clk_i,
    input  logic      rst_i,
    lsu_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [15:0] cnt;

    logic        hs;
    logic        illegal;
    logic        misaligned;
    logic        bad;
    logic        to_hit;
    logic        cap_rdata;
    logic [3:0]  be;
    logic [31:0] lanes;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign bus.req_ready_o = (state == S_IDLE) && !rst_i;
    assign hs              = bus.req_valid_i && bus.req_ready_o;

    // Legality is judged on the live request fields at the handshake.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (bus.req_we_i) begin
            illegal = bus.req_funct3_i[2] || (bus.req_funct3_i[1:0] == 2'b11);
        end else begin
            illegal = (bus.req_funct3_i == 3'b011) || (bus.req_funct3_i[2:1] == 2'b11);
        end
        misaligned = ((bus.req_funct3_i[1:0] == 2'b01) && bus.req_addr_i[0]) ||
                     ((bus.req_funct3_i[1:0] == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
        bad = illegal || misaligned;
    end

    // The counter saturates, so >= keeps a late grant into WAIT bounded.
    assign to_hit = (cnt >= 16'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_rdata = 1'b0;
        case (state)
            S_IDLE: begin
                if (hs) begin
                    state_nxt = bad ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_gnt_i) begin
                    if (we_q) begin
                        state_nxt = S_RESP;
                    end else if (bus.mem_rvalid_i) begin
                        // grant and data together: skip WAIT
                        cap_rdata = 1'b1;
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end else if (to_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    cap_rdata = 1'b1;
                    state_nxt = S_RESP;
                end else if (to_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (hs) begin
                we_q    <= bus.req_we_i;
                f3_q    <= bus.req_funct3_i;
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
                cnt     <= '0;
            end else if (((state == S_REQ) || (state == S_WAIT)) && (cnt != '1)) begin
                cnt <= cnt + 16'd1;
            end
            if (cap_rdata) begin
                rdata_q <= bus.mem_rdata_i;
            end
        end
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_q[1:0];
                lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                lanes = wdata_q;
            end
        endcase
    end

    always_comb begin
        shifted = rdata_q >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    // Memory-side outputs are gated by REQ so they read zero in every
    // other state, including immediately on reset.
    assign bus.mem_req_o    = (state == S_REQ);
    assign bus.mem_we_o     = bus.mem_req_o && we_q;
    assign bus.mem_addr_o   = bus.mem_req_o ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_be_o     = bus.mem_req_o ? be : '0;
    assign bus.mem_wdata_o  = bus.mem_req_o ? lanes : '0;

    assign bus.resp_valid_o = (state == S_RESP) || (state == S_ERR);
    assign bus.resp_err_o   = (state == S_ERR);
    assign bus.resp_rdata_o = ((state == S_RESP) && !we_q) ? ext : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- directed scoreboard bench for lsu_ctrl (TIMEOUT = 4).
// Stimulus pushes the expected response (error flag, load data, cycle)
// into a queue at each handshake; a negedge monitor pops and compares on
// every resp_valid_o. Memory-side outputs are checked by the stimulus
// task cycle by cycle while it plays the memory.
module tb_lsu_ctrl;
    localparam int TO = 4;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_ctrl_if bif ();

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic ready_due = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (ready_due) chk("req_ready_after_resp", 32'(bif.req_ready_o), 32'd1);
            ready_due = 1'b0;
            if (bif.resp_valid_o) begin
                ready_due = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(bif.resp_valid_o), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_err", 32'(bif.resp_err_o), 32'(mon_e.err));
                    chk("resp_rdata", bif.resp_rdata_o, mon_e.rdata);
                    chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    task automatic mem_idle();
        bif.mem_gnt_i    = 1'b0;
        bif.mem_rvalid_i = 1'b0;
        bif.mem_rdata_i  = JUNK;
    endtask

    // Present a request and wait for the handshake; afterwards the request
    // fields are scrambled so any failure to capture them shows up.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int hs_cyc, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        bif.req_valid_i  = 1'b1;
        bif.req_we_i     = we;
        bif.req_funct3_i = f3;
        bif.req_addr_i   = addr;
        bif.req_wdata_i  = wdata;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bif.req_ready_o;
        end
        hs_cyc = cyc;
        if (!ok) chk("handshake_timeout", 32'(bif.req_ready_o), 32'd1);
        @(posedge clk); #1;
        bif.req_valid_i  = 1'b0;
        bif.req_we_i     = ~we;
        bif.req_funct3_i = 3'b010;
        bif.req_addr_i   = ~addr;
        bif.req_wdata_i  = ~wdata;
    endtask

    // gnt_dly: grant in this REQ cycle (0 = never). rv_dly: rvalid this many
    // cycles after the grant (0 = with the grant, <0 = never).
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                       input logic [31:0] mrdata, input bit stray,
                       input logic exp_err, input logic [3:0] exp_be, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata, input int exp_lat);
        int  hs_cyc;
        int  nreq;
        int  nwait;
        bit  ok;
        issue(we, f3, addr, wdata, hs_cyc, ok);
        if (!ok) return;
        sb.push_back('{exp_err, exp_rdata, hs_cyc + exp_lat});
        if (exp_lat == 1) begin
            @(negedge clk);
            chk("no_mem_req_on_err", 32'(bif.mem_req_o), 32'd0);
        end else begin
            nreq = (gnt_dly == 0) ? TO : gnt_dly;
            for (int k = 1; k <= nreq; k++) begin
                if (k > 1) begin
                    @(posedge clk); #1;
                end
                bif.mem_gnt_i    = (k == gnt_dly);
                bif.mem_rvalid_i = ((k == gnt_dly) && (rv_dly == 0)) || (stray && (k < gnt_dly));
                bif.mem_rdata_i  = ((k == gnt_dly) && (rv_dly == 0)) ? mrdata : JUNK;
                @(negedge clk);
                chk("mem_req", 32'(bif.mem_req_o), 32'd1);
                chk("req_ready_busy", 32'(bif.req_ready_o), 32'd0);
                chk("mem_we", 32'(bif.mem_we_o), 32'(we));
                chk("mem_addr", bif.mem_addr_o, exp_addr);
                chk("mem_be", 32'(bif.mem_be_o), 32'(exp_be));
                if (we) chk("mem_wdata", bif.mem_wdata_o, exp_wdata);
            end
            if (gnt_dly == 0) begin
                @(posedge clk); #1;
                mem_idle();
                @(negedge clk);
                chk("mem_req_drop_timeout", 32'(bif.mem_req_o), 32'd0);
            end else if (!we && rv_dly != 0) begin
                nwait = (rv_dly < 0) ? (TO - gnt_dly + 1) : rv_dly;
                for (int j = 1; j <= nwait; j++) begin
                    @(posedge clk); #1;
                    bif.mem_gnt_i    = 1'b0;
                    bif.mem_rvalid_i = (j == rv_dly);
                    bif.mem_rdata_i  = (j == rv_dly) ? mrdata : JUNK;
                    @(negedge clk);
                    chk("mem_req_wait", 32'(bif.mem_req_o), 32'd0);
                end
            end
        end
        @(posedge clk); #1;
        mem_idle();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Pulse reset mid-cycle with a transaction in flight; nothing is
    // pushed for it, so any response for it is flagged by the monitor.
    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 32'(bif.req_ready_o), 32'd0);
        chk("rst_mem_req", 32'(bif.mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(bif.mem_we_o), 32'd0);
        chk("rst_mem_addr", bif.mem_addr_o, 32'd0);
        chk("rst_mem_be", 32'(bif.mem_be_o), 32'd0);
        chk("rst_mem_wdata", bif.mem_wdata_o, 32'd0);
        chk("rst_resp_valid", 32'(bif.resp_valid_o), 32'd0);
        mem_idle();
        @(posedge clk); #1;
        bif.mem_rvalid_i = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("ready_after_release", 32'(bif.req_ready_o), 32'd1);
        @(posedge clk); #1;
        mem_idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int  hs_cyc;
        bit  ok;
        bif.req_valid_i  = 1'b0;
        bif.req_we_i     = 1'b0;
        bif.req_funct3_i = '0;
        bif.req_addr_i   = '0;
        bif.req_wdata_i  = '0;
        mem_idle();
        #1 rst = 1'b1;
        #1;
        chk("reset_req_ready", 32'(bif.req_ready_o), 32'd0);
        chk("reset_mem_req", 32'(bif.mem_req_o), 32'd0);
        chk("reset_resp_valid", 32'(bif.resp_valid_o), 32'd0);
        chk("reset_resp_err", 32'(bif.resp_err_o), 32'd0);
        chk("reset_resp_rdata", bif.resp_rdata_o, 32'd0);
        chk("reset_mem_be", 32'(bif.mem_be_o), 32'd0);
        chk("reset_mem_addr", bif.mem_addr_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("reset_release_ready", 32'(bif.req_ready_o), 32'd1);

        //   we f3      addr          wdata          gnt rv  mrdata        stray err be       addr          wdata          rdata         lat
        txn(0, 3'b000, 32'h0000_1003, 32'h0,         1,  1, 32'h80FF_1234, 0,    0, 4'b1000, 32'h0000_1000, 32'h0,         32'hFFFF_FF80, 3);
        txn(0, 3'b101, 32'h0000_2002, 32'h0,         2,  0, 32'hBEEF_0000, 1,    0, 4'b1100, 32'h0000_2000, 32'h0,         32'h0000_BEEF, 3);
        txn(0, 3'b001, 32'h0000_2002, 32'h0,         1,  2, 32'hBEEF_0000, 0,    0, 4'b1100, 32'h0000_2000, 32'h0,         32'hFFFF_BEEF, 4);
        txn(1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 3,  0, 32'h7777_7777, 1,    0, 4'b0010, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0,         4);
        txn(1, 3'b001, 32'h0000_0022, 32'hCAFE_BABE, 1,  0, 32'h0,         0,    0, 4'b1100, 32'h0000_0020, 32'hBABE_BABE, 32'h0,         2);
        txn(1, 3'b010, 32'h0000_0030, 32'h89AB_CDEF, 2,  0, 32'h0,         0,    0, 4'b1111, 32'h0000_0030, 32'h89AB_CDEF, 32'h0,         3);
        txn(1, 3'b000, 32'h0000_0013, 32'h1234_5678, 1,  0, 32'h0,         0,    0, 4'b1000, 32'h0000_0010, 32'h7878_7878, 32'h0,         2);
        txn(0, 3'b010, 32'h0000_0044, 32'h0,         1,  1, 32'h1357_9BDF, 0,    0, 4'b1111, 32'h0000_0044, 32'h0,         32'h1357_9BDF, 3);
        txn(0, 3'b000, 32'h0000_1002, 32'h0,         1,  1, 32'h80FF_1234, 0,    0, 4'b0100, 32'h0000_1000, 32'h0,         32'hFFFF_FFFF, 3);
        txn(0, 3'b100, 32'h0000_1002, 32'h0,         1,  0, 32'h80FF_1234, 0,    0, 4'b0100, 32'h0000_1000, 32'h0,         32'h0000_00FF, 2);
        txn(0, 3'b001, 32'h0000_1000, 32'h0,         1,  1, 32'h0000_8001, 0,    0, 4'b0011, 32'h0000_1000, 32'h0,         32'hFFFF_8001, 3);
        // handshake-time errors
        txn(0, 3'b010, 32'h0000_0006, 32'h0,         1,  0, 32'h0,         0,    1, 4'b0000, 32'h0,         32'h0,         32'h0,         1);
        txn(1, 3'b100, 32'h0000_0008, 32'h0,         1,  0, 32'h0,         0,    1, 4'b0000, 32'h0,         32'h0,         32'h0,         1);
        txn(0, 3'b001, 32'h0000_0003, 32'h0,         1,  0, 32'h0,         0,    1, 4'b0000, 32'h0,         32'h0,         32'h0,         1);
        txn(0, 3'b101, 32'h0000_0005, 32'h0,         1,  0, 32'h0,         0,    1, 4'b0000, 32'h0,         32'h0,         32'h0,         1);
        txn(0, 3'b011, 32'h0000_0000, 32'h0,         1,  0, 32'h0,         0,    1, 4'b0000, 32'h0,         32'h0,         32'h0,         1);
        txn(0, 3'b110, 32'h0000_0000, 32'h0,         1,  0, 32'h0,         0,    1, 4'b0000, 32'h0,         32'h0,         32'h0,         1);
        txn(1, 3'b101, 32'h0000_0000, 32'h0,         1,  0, 32'h0,         0,    1, 4'b0000, 32'h0,         32'h0,         32'h0,         1);
        // timeout boundaries (TIMEOUT = 4)
        txn(0, 3'b010, 32'h0000_0040, 32'h0,         0, -1, 32'h0,         0,    1, 4'b1111, 32'h0000_0040, 32'h0,         32'h0,         5);
        txn(1, 3'b010, 32'h0000_0048, 32'h5555_AAAA, 4,  0, 32'h0,         0,    0, 4'b1111, 32'h0000_0048, 32'h5555_AAAA, 32'h0,         5);
        txn(0, 3'b010, 32'h0000_004C, 32'h0,         4,  0, 32'h0BAD_F00D, 0,    0, 4'b1111, 32'h0000_004C, 32'h0,         32'h0BAD_F00D, 5);
        txn(0, 3'b010, 32'h0000_0050, 32'h0,         2, -1, 32'h0,         0,    1, 4'b1111, 32'h0000_0050, 32'h0,         32'h0,         5);
        txn(0, 3'b010, 32'h0000_0054, 32'h0,         1,  3, 32'h600D_CAFE, 0,    0, 4'b1111, 32'h0000_0054, 32'h0,         32'h600D_CAFE, 5);

        // reset while waiting for read data
        issue(0, 3'b010, 32'h0000_0060, 32'h0, hs_cyc, ok);
        bif.mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("rst_wait_mem_req", 32'(bif.mem_req_o), 32'd1);
        @(posedge clk); #1;
        mem_idle();
        @(negedge clk);
        chk("rst_wait_in_wait", 32'(bif.mem_req_o), 32'd0);
        reset_pulse();
        txn(0, 3'b000, 32'h0000_1003, 32'h0,         1,  1, 32'h80FF_1234, 0,    0, 4'b1000, 32'h0000_1000, 32'h0,         32'hFFFF_FF80, 3);

        // reset while the memory request is up
        issue(1, 3'b010, 32'h0000_0070, 32'h1111_2222, hs_cyc, ok);
        @(negedge clk);
        chk("rst_req_mem_req", 32'(bif.mem_req_o), 32'd1);
        reset_pulse();
        txn(1, 3'b001, 32'h0000_0072, 32'h0000_F00D, 1,  0, 32'h0,         0,    0, 4'b1100, 32'h0000_0070, 32'hF00D_F00D, 32'h0,         2);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1);
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles spent in REQ plus WAIT before an error is reported; legal range 1..65535.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  input  1  core presents a load/store.
REQ-005 req_ready_o  output  1  controller accepts a request; high only in IDLE.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_funct3_i  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  store data, right-aligned.
REQ-010 resp_valid_o  output  1  one-cycle completion pulse.
REQ-011 resp_err_o  output  1  qualifies resp_valid_o; 1 = misaligned, illegal funct3 or timeout.
REQ-012 resp_rdata_o  output  32  extended load data; valid with resp_valid_o on loads.
REQ-013 mem_req_o  output  1  memory request.
REQ-014 mem_we_o  output  1  memory write enable.
REQ-015 mem_addr_o  output  32  word address, bits [1:0] always 00.
REQ-016 mem_be_o  output  4  byte enables.
REQ-017 mem_wdata_o  output  32  store data replicated into the lanes selected by mem_be_o.
REQ-018 mem_gnt_i  input  1  memory accepted the request.
REQ-019 mem_rvalid_i  input  1  read data valid.
REQ-020 mem_rdata_i  input  32  read word.

Function
REQ-021 FSM states: IDLE, REQ, WAIT, RESP, ERR.
- IDLE -> ERR: on a handshake with a misaligned or illegal access.
- IDLE -> REQ: on a handshake with a legal access.
REQ-022 The request fields are captured in registers at the handshake (req_valid_i & req_ready_o); later changes on req_* are ignored.
REQ-023 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=00. Illegal: funct3 011, 110 or 111 on loads; any funct3 other than 000/001/010 on stores.
REQ-024 In REQ:
- mem_req_o is held high with stable mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o until mem_gnt_i.
- On grant, a store goes to RESP and a load goes to WAIT.
- mem_gnt_i and mem_rvalid_i in the same cycle for a load go directly to RESP using that data.
REQ-025 WAIT: mem_req_o low; on mem_rvalid_i, the rdata is captured and the FSM goes to RESP.
REQ-026 mem_be_o by size with offset o = addr[1:0]: B = 0001<<o, H = 0011<<o, W = 1111.
REQ-027 mem_wdata_o lanes: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.
REQ-028 Load extract: shift the captured word right by 8*o, then extend.
- B: sign-extend from bit 7.
- H: sign-extend from bit 15.
- BU and HU: zero-extend.
- W: unchanged.
REQ-029 RESP and ERR last exactly one cycle each:
- Both assert resp_valid_o and return to IDLE.
- resp_err_o = 1 only in ERR.
- resp_rdata_o = 0 in ERR and for stores.
REQ-030 Timeout counter:
- Cleared at the handshake; increments each cycle in REQ or WAIT.
- On reaching TIMEOUT without the awaited grant or rvalid, the FSM goes to ERR and mem_req_o drops.
- A grant or rvalid arriving in the same cycle as the limit wins over the timeout.
REQ-031 A mem_rvalid_i outside WAIT (and outside the same-cycle REQ case) is ignored.
REQ-032 Latency from handshake at cycle N:
- mem_req_o is high in cycle N+1.
- A zero-wait store responds in N+2.
- A load with gnt at N+1 and rvalid at N+2 responds in N+3.
- An error detected at the handshake responds in N+1.
REQ-033 There is exactly one outstanding request; req_ready_o returns high in the cycle after resp_valid_o.

Reset
REQ-034 rst_i asserted forces, immediately and regardless of clk_i:
- State IDLE and counter 0.
- req_ready_o = 0 while rst_i is high, and 1 in the first cycle after release.
- All other outputs 0.
REQ-035 Reset in the middle of a transaction abandons it: no resp_valid_o is generated for it and mem_req_o drops asynchronously.

Verification
REQ-036 LB addr 0x1003 with mem_rdata 0x80FF_1234 -> mem_be 1000, mem_addr 0x1000, resp_rdata 0xFFFF_FF80.
REQ-037 LHU addr 0x2002 with rdata 0xBEEF_0000 -> mem_be 1100, resp_rdata 0x0000_BEEF; LH gives 0xFFFF_BEEF.
REQ-038 SB addr 0x11, wdata 0x0000_00A5, gnt after 3 cycles -> mem_req held 3 cycles, mem_be 0010, mem_wdata 0xA5A5_A5A5, resp_valid 1 cycle after grant, resp_err 0.
REQ-039 LW addr 0x6 -> no mem_req_o, resp_valid and resp_err in the next cycle; SW with funct3 100 gives the same result.
REQ-040 TIMEOUT = 4 load with no gnt -> mem_req_o high 4 cycles then low, resp_err pulse; a second run with gnt in cycle 4 completes normally.
REQ-041 rst_i pulsed during WAIT -> outputs 0 immediately, no response; a new request after release completes correctly.
